// File: rtl/piradspi_sub_engine.sv
// SPI subordinate engine: oversamples sclk/csn/mosi in the clk domain, deserialises
// mosi onto an rx stream and serialises tx stream words onto miso, run-time cpol/cpha.
module piradspi_sub_engine #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sclk,
  input  logic                  csn,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_tdata,
  input  logic                  tx_tvalid,
  output logic                  tx_tready,
  output logic [DATA_WIDTH-1:0] rx_tdata,
  output logic                  rx_tvalid,
  input  logic                  rx_tready,
  output logic                  selected,
  output logic                  word_done,
  output logic                  underrun,
  output logic                  overrun,
  output logic                  aborted
);
  // state  | meaning
  // IDLE   | deselected, waiting for a synchronised csn fall
  // LOAD   | one cycle: latch mode, load first tx word
  // ACTIVE | shifting bits until csn rises
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, csn_prev_q;
  logic                   cpol_q, cpol_d, cpha_q, cpha_d;
  logic                   sel_q, sel_d, oe_q, oe_d, miso_q, miso_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;

  logic                  sclk_s, csn_s, mosi_s, sclk_edge, lead, trail;
  logic                  sample_edge, shift_edge, word_complete;
  logic                  tx_head, load_head;
  logic [DATA_WIDTH-1:0] tx_shl, rx_next, load_word, load_shl;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s       = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_edge   = sclk_s ^ sclk_prev_q;
  assign lead        = sclk_edge & (sclk_s != cpol_q);
  assign trail       = sclk_edge & (sclk_s == cpol_q);
  assign sample_edge = (state_q == ACTIVE) & (cpha_q ? trail : lead);
  assign shift_edge  = (state_q == ACTIVE) & (cpha_q ? lead : trail);
  assign word_complete = sample_edge & (cnt_q == CW'(DATA_WIDTH - 1));

  assign tx_head   = MSB_FIRST ? tx_sr_q[DATA_WIDTH-1] : tx_sr_q[0];
  assign tx_shl    = MSB_FIRST ? {tx_sr_q[DATA_WIDTH-2:0], 1'b0} : {1'b0, tx_sr_q[DATA_WIDTH-1:1]};
  assign rx_next   = MSB_FIRST ? {rx_sr_q[DATA_WIDTH-2:0], mosi_s} : {mosi_s, rx_sr_q[DATA_WIDTH-1:1]};
  assign load_word = tx_tvalid ? tx_tdata : '0;
  assign load_head = MSB_FIRST ? load_word[DATA_WIDTH-1] : load_word[0];
  assign load_shl  = MSB_FIRST ? {load_word[DATA_WIDTH-2:0], 1'b0} : {1'b0, load_word[DATA_WIDTH-1:1]};

  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    sel_d      = sel_q;
    oe_d       = oe_q;
    miso_d     = miso_q;
    cnt_d      = cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    tx_tready  = 1'b0;
    underrun   = 1'b0;
    word_done  = 1'b0;
    overrun    = 1'b0;
    aborted    = 1'b0;

    if (rx_valid_q && rx_tready) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!csn_s && csn_prev_q) state_d = LOAD;
      end
      LOAD: begin
        cpol_d    = cpol;
        cpha_d    = cpha;
        sel_d     = 1'b1;
        oe_d      = 1'b1;
        cnt_d     = '0;
        rx_sr_d   = '0;
        tx_tready = tx_tvalid;
        underrun  = ~tx_tvalid;
        // cpha=0 needs the first bit on the wire before the first (sampling) edge
        if (!cpha) begin
          miso_d  = load_head;
          tx_sr_d = load_shl;
        end else begin
          miso_d  = 1'b0;
          tx_sr_d = load_word;
        end
        state_d = ACTIVE;
      end
      ACTIVE: begin
        if (shift_edge) begin
          miso_d  = tx_head;
          tx_sr_d = tx_shl;
        end
        if (sample_edge) begin
          rx_sr_d = rx_next;
          cnt_d   = cnt_q + CW'(1);
        end
        if (word_complete) begin
          cnt_d     = '0;
          word_done = 1'b1;
          tx_tready = tx_tvalid;
          underrun  = ~tx_tvalid;
          tx_sr_d   = load_word;
          if (rx_valid_q && !rx_tready) begin
            overrun = 1'b1;
          end else begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
          end
        end
        // level check so a csn rise landing in LOAD is not lost; edge above is processed first
        if (csn_s) begin
          aborted = (cnt_d != '0);
          cnt_d   = '0;
          sel_d   = 1'b0;
          oe_d    = 1'b0;
          miso_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
      state_q     <= IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      sel_q       <= 1'b0;
      oe_q        <= 1'b0;
      miso_q      <= 1'b0;
      cnt_q       <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      sel_q       <= sel_d;
      oe_q        <= oe_d;
      miso_q      <= miso_d;
      cnt_q       <= cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = oe_q;
  assign selected  = sel_q;
  assign rx_tdata  = rx_data_q;
  assign rx_tvalid = rx_valid_q;
endmodule

// File: tb/tb_piradspi_sub_engine.sv
// Scoreboard bench for piradspi_sub_engine: a bit-banged SPI initiator drives frames,
// expected rx words are queued and a monitor checks every accepted rx beat.
module tb_piradspi_sub_engine;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, csn = 1'b1, mosi = 1'b0;
  logic        miso, miso_oe, tx_tready, rx_tvalid, selected;
  logic        word_done, underrun, overrun, aborted;
  logic [31:0] tx_tdata = '0, rx_tdata;
  logic        tx_tvalid = 1'b0, rx_tready = 1'b1;

  int checks = 0, errors = 0;
  int n_wd = 0, n_txr = 0, n_und = 0, n_ovr = 0, n_abt = 0;
  int s_wd, s_txr, s_und, s_ovr, s_abt;
  logic [31:0] rxq[$];
  logic [31:0] txq[$];
  logic [31:0] mo_w[0:1];
  logic [31:0] mi_w[0:1];

  piradspi_sub_engine #(.DATA_WIDTH(32), .SYNC_STAGES(SYNC), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rstn(rstn), .cpol(cpol), .cpha(cpha), .sclk(sclk), .csn(csn),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .tx_tdata(tx_tdata),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .rx_tdata(rx_tdata),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .selected(selected),
    .word_done(word_done), .underrun(underrun), .overrun(overrun), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // rx monitor: each accepted beat must match the head of the expected queue
  initial forever begin
    @(negedge clk);
    if (rx_tvalid && rx_tready) begin
      if (rxq.size() == 0) chk("rx_unexpected", rx_tdata, 32'hxxxxxxxx);
      else chk("rx_data", rx_tdata, rxq.pop_front());
    end
  end

  // pulse counters
  initial forever begin
    @(negedge clk);
    n_wd  += int'(word_done);
    n_txr += int'(tx_tready);
    n_und += int'(underrun);
    n_ovr += int'(overrun);
    n_abt += int'(aborted);
  end

  // tx source: presents the head of txq, pops it after the consuming edge
  initial forever begin
    @(negedge clk);
    if (tx_tvalid && tx_tready) begin
      @(posedge clk);
      #1;
      void'(txq.pop_front());
    end
    tx_tvalid = (txq.size() > 0);
    tx_tdata  = (txq.size() > 0) ? txq[0] : 32'h0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic snap();
    s_wd = n_wd; s_txr = n_txr; s_und = n_und; s_ovr = n_ovr; s_abt = n_abt;
  endtask

  task automatic chk_counts(input string name, input int wd, input int txr, input int und,
                            input int ovr, input int abt);
    chk({name, "_word_done"}, 32'(n_wd - s_wd), 32'(wd));
    chk({name, "_tx_tready"}, 32'(n_txr - s_txr), 32'(txr));
    chk({name, "_underrun"}, 32'(n_und - s_und), 32'(und));
    chk({name, "_overrun"}, 32'(n_ovr - s_ovr), 32'(ovr));
    chk({name, "_aborted"}, 32'(n_abt - s_abt), 32'(abt));
  endtask

  // SPI initiator at clk/8: mosi from mo_w, miso captured into mi_w, MSB first
  task automatic spi_frame(input int nbits, input logic p, input logic h);
    int w, i;
    cpol = p; cpha = h; sclk = p;
    repeat (4) @(negedge clk);
    csn = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      w = b / 32;
      i = 31 - (b % 32);
      if (b == 0) chk("sel_oe_active", {30'd0, selected, miso_oe}, 32'd3);
      if (!h) mosi = mo_w[w][i];
      repeat (4) @(negedge clk);
      sclk = ~p;
      if (h) mosi = mo_w[w][i];
      else mi_w[w][i] = miso;
      repeat (4) @(negedge clk);
      sclk = p;
      if (h) mi_w[w][i] = miso;
    end
    repeat (4) @(negedge clk);
    csn = 1'b1;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    chk("deselect_sel_oe", {30'd0, selected, miso_oe}, 32'd0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {23'd0, miso, miso_oe, tx_tready, rx_tvalid, selected,
                          word_done, underrun, overrun, aborted}, 32'd0);
    chk("reset_rx_tdata", rx_tdata, 32'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // mode 0 single word
    snap();
    txq.push_back(32'hA5A50F0F);
    mo_w[0] = 32'h12345678;
    rxq.push_back(32'h12345678);
    spi_frame(32, 1'b0, 1'b0);
    chk("m0_miso", mi_w[0], 32'hA5A50F0F);
    chk("m0_rx_drained", 32'(rxq.size()), 32'd0);
    // end-of-word reload finds the tx source empty
    chk_counts("m0", 1, 1, 1, 0, 0);

    // mode 3, two words without a csn gap
    snap();
    txq.push_back(32'h11111111);
    txq.push_back(32'h22222222);
    mo_w[0] = 32'hDEADBEEF; mo_w[1] = 32'h00000001;
    rxq.push_back(32'hDEADBEEF);
    rxq.push_back(32'h00000001);
    spi_frame(64, 1'b1, 1'b1);
    chk("m3_miso_w0", mi_w[0], 32'h11111111);
    chk("m3_miso_w1", mi_w[1], 32'h22222222);
    chk("m3_rx_drained", 32'(rxq.size()), 32'd0);
    chk_counts("m3", 2, 2, 1, 0, 0);

    // overrun: consumer stalled across two words
    snap();
    @(posedge clk); #1 rx_tready = 1'b0;
    txq.push_back(32'h0F0F0F0F);
    txq.push_back(32'hF0F0F0F0);
    mo_w[0] = 32'hCAFEF00D; mo_w[1] = 32'h0BADC0DE;
    rxq.push_back(32'hCAFEF00D);
    spi_frame(64, 1'b0, 1'b0);
    chk("ovr_miso_w1", mi_w[1], 32'hF0F0F0F0);
    chk("ovr_rx_tvalid_held", {31'd0, rx_tvalid}, 32'd1);
    chk("ovr_rx_tdata_held", rx_tdata, 32'hCAFEF00D);
    chk_counts("ovr", 2, 2, 1, 1, 0);
    @(posedge clk); #1 rx_tready = 1'b1;
    repeat (4) @(negedge clk);
    chk("ovr_rx_drained", 32'(rxq.size()), 32'd0);
    chk("ovr_rx_tvalid_clear", {31'd0, rx_tvalid}, 32'd0);

    // underrun: no tx word at select, mode 1
    snap();
    mo_w[0] = 32'h5A5AC3C3;
    rxq.push_back(32'h5A5AC3C3);
    spi_frame(32, 1'b0, 1'b1);
    chk("und_miso", mi_w[0], 32'h00000000);
    chk("und_rx_drained", 32'(rxq.size()), 32'd0);
    chk_counts("und", 1, 0, 2, 0, 0);

    // abort after 13 bits, then a full transfer
    snap();
    mo_w[0] = 32'hFFFFFFFF;
    spi_frame(13, 1'b0, 1'b0);
    chk("abt_no_rx_tvalid", {31'd0, rx_tvalid}, 32'd0);
    chk_counts("abt", 0, 0, 1, 0, 1);
    snap();
    txq.push_back(32'h96969696);
    mo_w[0] = 32'h0F1E2D3C;
    rxq.push_back(32'h0F1E2D3C);
    spi_frame(32, 1'b0, 1'b0);
    chk("post_abt_miso", mi_w[0], 32'h96969696);
    chk("post_abt_rx_drained", 32'(rxq.size()), 32'd0);
    chk_counts("post_abt", 1, 1, 1, 0, 0);

    // asynchronous reset around bit 20 of a frame
    txq.push_back(32'h77777777);
    mo_w[0] = 32'hAAAA5555;
    fork
      spi_frame(32, 1'b0, 1'b0);
      begin
        repeat (174) @(negedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("async_rst_outputs", {23'd0, miso, miso_oe, tx_tready, rx_tvalid, selected,
                                  word_done, underrun, overrun, aborted}, 32'd0);
        chk("async_rst_rx_tdata", rx_tdata, 32'd0);
      end
    join
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    txq.delete();
    repeat (2) @(negedge clk);
    snap();
    txq.push_back(32'h3C3C5AA5);
    mo_w[0] = 32'h87654321;
    rxq.push_back(32'h87654321);
    spi_frame(32, 1'b1, 1'b0);
    chk("post_rst_miso", mi_w[0], 32'h3C3C5AA5);
    chk("post_rst_rx_drained", 32'(rxq.size()), 32'd0);
    chk_counts("post_rst", 1, 1, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
